// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-side arbiter.
//   arb_state_e - arbiter FSM state
//   idx_width() - index width for an n-entry set, never below one bit
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester bus plus FIFO write-port signals of the arbiter.
//   req_valid/req_data/req_ready - per-requester word handshake (NREQ lanes)
//   fifo_full/fifo_wr/fifo_data  - FIFO write port
//   fifo_src                     - requester index of the word on fifo_data
//   gnt/busy                     - registered grant and GRANT-state flag
// master is the arbiter side, slave the requester/FIFO side.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned IdxW = idx_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_wr;
    logic [WIDTH-1:0]      fifo_data;
    logic [IdxW-1:0]       fifo_src;
    logic [NREQ-1:0]       gnt;
    logic                  busy;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr, fifo_data, fifo_src, gnt, busy
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr, fifo_data, fifo_src, gnt, busy
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   - request vector
//   start - index the search begins at (wraps modulo NREQ)
//   found - some request bit is set
//   idx   - first set index at or after start, modulo NREQ
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]             req,
    input  logic [idx_width(NREQ)-1:0]  start,
    output logic                        found,
    output logic [idx_width(NREQ)-1:0]  idx
);
    localparam int unsigned IdxW = idx_width(NREQ);

    int unsigned     pos;
    logic [IdxW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos  = (int'(start) + k) % NREQ;
            cand = IdxW'(pos);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NREQ
// requesters in the wr_clk domain.
//   wr_clk - write-domain clock, rising edge
//   rst    - asynchronous active-low reset
//   bus    - fifo_wr_arbiter_if.master: requester handshake, FIFO write port,
//            source index, registered one-hot grant and busy flag
// A grant lasts up to MAX_BURST words; it is released early when the owner drops
// valid, and handed straight to the next round-robin winner without a bubble.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              wr_clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int unsigned     IdxW    = idx_width(NREQ);
    localparam int unsigned     CntW    = idx_width(MAX_BURST);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NREQ - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(MAX_BURST - 1);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

    logic            in_grant;
    logic            valid_g;
    logic            xfer;
    logic            rel;
    logic [IdxW-1:0] next_idx;
    logic [IdxW-1:0] pick_start;
    logic            pick_found;
    logic [IdxW-1:0] pick_idx;

    assign in_grant = (state_q == StGrant);
    assign valid_g  = bus.req_valid[gnt_idx_q];
    assign xfer     = in_grant && valid_g && !bus.fifo_full;
    assign rel      = in_grant && ((xfer && (burst_cnt_q == LastCnt)) || !valid_g);
    assign next_idx = (gnt_idx_q == LastIdx) ? '0 : gnt_idx_q + 1'b1;

    // One picker serves both paths: from rr_ptr when idle, from g+1 on release.
    assign pick_start = in_grant ? next_idx : rr_ptr_q;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (bus.req_valid),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        bus.fifo_wr   = xfer;
        bus.req_ready = '0;
        if (in_grant && !bus.fifo_full) begin
            bus.req_ready[gnt_idx_q] = 1'b1;
        end
        bus.fifo_data = bus.req_data[WIDTH-1:0];
        for (int i = 1; i < NREQ; i++) begin
            if (gnt_idx_q == IdxW'(i)) begin
                bus.fifo_data = bus.req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.fifo_src = gnt_idx_q;
    assign bus.gnt      = gnt_q;
    assign bus.busy     = in_grant;

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        burst_cnt_d = burst_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d     = StGrant;
                    gnt_idx_d   = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            StGrant: begin
                if (rel) begin
                    rr_ptr_d    = next_idx;
                    burst_cnt_d = '0;
                    if (pick_found) begin
                        gnt_idx_d = pick_idx;
                    end else begin
                        state_d   = StIdle;
                        gnt_idx_d = '0;
                    end
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        gnt_d = '0;
        if (state_d == StGrant) begin
            gnt_d[gnt_idx_d] = 1'b1;
        end
    end

    always_ff @(posedge wr_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            gnt_idx_q   <= '0;
            gnt_q       <= '0;
            burst_cnt_q <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_q       <= gnt_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule
